userinput_multi: RTL and testbench

- N-channel user key conditioner; successor to the single-key press detector.
- Each channel runs a 2-flop synchroniser, then a debounce filter, then an edge/auto-repeat pulse generator.
- Emits one-cycle event pulses plus a debounced level per channel.
- Sits between board keys/switches and the game control logic (step, run, cursor keys).

---
 rtl/userinput_multi.sv | 152 +++++++++++++++
 tb/tb_userinput_multi.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/userinput_multi.sv
// N-channel key conditioner: per channel a 2-flop synchroniser, a debounce filter and
// an edge / auto-repeat pulse generator, producing a debounced level and 1-cycle pulses.
module userinput_multi #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] key,
    input  logic [1:0]   mode,
    output logic [N-1:0] level,
    output logic [N-1:0] out
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HELD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    localparam logic [1:0] MODE_PRESS   = 2'b00;
    localparam logic [1:0] MODE_RELEASE = 2'b01;
    localparam logic [1:0] MODE_BOTH    = 2'b10;
    localparam logic [1:0] MODE_REPEAT  = 2'b11;

    logic w_modeRepeat;
    logic w_modeRise;
    logic w_modeFall;

    // Mode is decoded once and shared by every channel; it is never latched.
    assign w_modeRepeat = (mode == MODE_REPEAT);
    assign w_modeRise   = (mode != MODE_RELEASE);
    assign w_modeFall   = (mode == MODE_RELEASE) || (mode == MODE_BOTH);

    for (genvar i = 0; i < N; i++) begin : g_chan
        logic          r_sync1;
        logic          r_sync2;
        logic          r_level;
        logic          r_out;
        logic [DW-1:0] r_dbCnt;
        logic [1:0]    r_state;
        logic [RW-1:0] r_repCnt;

        logic          w_mismatch;
        logic          w_flip;
        logic          w_rise;
        logic          w_fall;
        logic [1:0]    w_nextState;
        logic [RW-1:0] w_nextRepCnt;
        logic          w_repPulse;
        logic          w_pulse;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= key[i];
                r_sync2 <= r_sync1;
            end
        end

        // Rise/fall are the cycles in which the debounced level is about to flip,
        // so the pulse register lands in the same cycle as the new level.
        assign w_mismatch = (r_sync2 != r_level);
        assign w_flip     = w_mismatch && (r_dbCnt == DB_LAST);
        assign w_rise     = w_flip && r_sync2;
        assign w_fall     = w_flip && !r_sync2;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_dbCnt <= '0;
                r_level <= 1'b0;
            end else if (!w_mismatch) begin
                r_dbCnt <= '0;
            end else if (r_dbCnt == DB_LAST) begin
                r_level <= r_sync2;
                r_dbCnt <= '0;
            end else begin
                r_dbCnt <= r_dbCnt + DW'(1);
            end
        end

        // Leaving repeat mode or releasing the key always drops back to IDLE, so
        // re-entering mode 11 with the key still down waits for a fresh press.
        always_comb begin
            w_nextState  = r_state;
            w_nextRepCnt = r_repCnt;
            w_repPulse   = 1'b0;
            if (!w_modeRepeat || w_fall) begin
                w_nextState  = IDLE;
                w_nextRepCnt = '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            w_nextState  = HELD;
                            w_nextRepCnt = '0;
                        end
                    end
                    HELD: begin
                        if (r_repCnt == DELAY_LAST) begin
                            w_repPulse   = 1'b1;
                            w_nextState  = REPEAT;
                            w_nextRepCnt = '0;
                        end else begin
                            w_nextRepCnt = r_repCnt + RW'(1);
                        end
                    end
                    REPEAT: begin
                        if (r_repCnt == PERIOD_LAST) begin
                            w_repPulse   = 1'b1;
                            w_nextRepCnt = '0;
                        end else begin
                            w_nextRepCnt = r_repCnt + RW'(1);
                        end
                    end
                    default: begin
                        w_nextState  = IDLE;
                        w_nextRepCnt = '0;
                    end
                endcase
            end
        end

        assign w_pulse = (w_rise && w_modeRise) || (w_fall && w_modeFall) || w_repPulse;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_state  <= IDLE;
                r_repCnt <= '0;
                r_out    <= 1'b0;
            end else begin
                r_state  <= w_nextState;
                r_repCnt <= w_nextRepCnt;
                r_out    <= w_pulse;
            end
        end

        assign level[i] = r_level;
        assign out[i]   = r_out;
    end

endmodule

// File: tb/tb_userinput_multi.sv
// Directed bench for userinput_multi: a cycle table for reset/debounce/edge modes,
// then hand-written sequences for auto-repeat, mode switching and mid-press reset.
module tb_userinput_multi;

    logic       clock;
    logic       reset;
    logic [3:0] key;
    logic [1:0] mode;
    logic [3:0] level;
    logic [3:0] out;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic       rstN;
        logic [3:0] key;
        logic [1:0] mode;
        logic [3:0] expLevel;
        logic [3:0] expOut;
    } vec_t;

    vec_t vecs[$];

    userinput_multi #(
        .N(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key(key),
        .mode(mode),
        .level(level),
        .out(out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic addRows(input int n, input logic rstN, input logic [3:0] k,
                           input logic [1:0] m, input logic [3:0] el, input logic [3:0] eo);
        vec_t v;
        v.rstN = rstN; v.key = k; v.mode = m; v.expLevel = el; v.expOut = eo;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic rstN, input logic [3:0] k, input logic [1:0] m);
        reset = rstN;
        key   = k;
        mode  = m;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expLevel, input logic [3:0] expOut);
        checkCount++;
        if (level !== expLevel)
            $display("[TB] FAIL %s level: got %h, expected %h", name, level, expLevel);
        else
            passCount++;
        checkCount++;
        if (out !== expOut)
            $display("[TB] FAIL %s out: got %h, expected %h", name, out, expOut);
        else
            passCount++;
    endtask

    task automatic cycle(input logic rstN, input logic [3:0] k, input logic [1:0] m,
                         input string name, input logic [3:0] el, input logic [3:0] eo);
        applyStimulus(rstN, k, m);
        @(posedge clock);
        #1;
        checkOutput(name, el, eo);
    endtask

    initial begin
        logic [3:0] el;
        logic [3:0] eo;
        logic [3:0] k;
        logic [1:0] m;

        applyStimulus(1'b0, 4'hF, 2'b00);

        // reset held with keys down, then released: all four rise together
        addRows(2, 1'b0, 4'hF, 2'b00, 4'h0, 4'h0);
        addRows(5, 1'b1, 4'hF, 2'b00, 4'h0, 4'h0);
        addRows(1, 1'b1, 4'hF, 2'b00, 4'hF, 4'hF);
        addRows(1, 1'b1, 4'hF, 2'b00, 4'hF, 4'h0);
        addRows(5, 1'b1, 4'h0, 2'b00, 4'hF, 4'h0);
        addRows(2, 1'b1, 4'h0, 2'b00, 4'h0, 4'h0);
        // 3-cycle glitch rejected, 4+ cycle hold accepted
        addRows(3, 1'b1, 4'h1, 2'b00, 4'h0, 4'h0);
        addRows(4, 1'b1, 4'h0, 2'b00, 4'h0, 4'h0);
        addRows(5, 1'b1, 4'h1, 2'b00, 4'h0, 4'h0);
        addRows(1, 1'b1, 4'h1, 2'b00, 4'h1, 4'h1);
        addRows(2, 1'b1, 4'h1, 2'b00, 4'h1, 4'h0);
        // mode 01 on key[1]: pulse only at the fall
        addRows(5, 1'b1, 4'h3, 2'b01, 4'h1, 4'h0);
        addRows(2, 1'b1, 4'h3, 2'b01, 4'h3, 4'h0);
        addRows(5, 1'b1, 4'h1, 2'b01, 4'h3, 4'h0);
        addRows(1, 1'b1, 4'h1, 2'b01, 4'h1, 4'h2);
        addRows(1, 1'b1, 4'h1, 2'b01, 4'h1, 4'h0);
        // mode 10 on key[1]: pulses at rise and fall
        addRows(5, 1'b1, 4'h3, 2'b10, 4'h1, 4'h0);
        addRows(1, 1'b1, 4'h3, 2'b10, 4'h3, 4'h2);
        addRows(1, 1'b1, 4'h3, 2'b10, 4'h3, 4'h0);
        addRows(5, 1'b1, 4'h1, 2'b10, 4'h3, 4'h0);
        addRows(1, 1'b1, 4'h1, 2'b10, 4'h1, 4'h2);
        addRows(1, 1'b1, 4'h1, 2'b10, 4'h1, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rstN, vecs[i].key, vecs[i].mode, $sformatf("vec%0d", i),
                  vecs[i].expLevel, vecs[i].expOut);
        end

        // auto-repeat on key[2]: press at 5, repeats 13,17,...; release at 30 -> fall at 35
        for (int c = 0; c <= 40; c++) begin
            k  = (c < 30) ? 4'h5 : 4'h1;
            el = (c >= 5 && c < 35) ? 4'h5 : 4'h1;
            eo = (c == 5 || (c >= 13 && c < 35 && (c - 13) % 4 == 0)) ? 4'h4 : 4'h0;
            cycle(1'b1, k, 2'b11, $sformatf("repeat%0d", c), el, eo);
        end

        // mode dropped to 00 mid-repeat, then back to 11 while still held
        for (int c = 0; c <= 35; c++) begin
            m  = (c >= 18 && c < 22) ? 2'b00 : 2'b11;
            el = (c >= 5) ? 4'h5 : 4'h1;
            eo = (c == 5 || c == 13 || c == 17) ? 4'h4 : 4'h0;
            cycle(1'b1, 4'h5, m, $sformatf("modesw%0d", c), el, eo);
        end

        // release key[2] in mode 11: no release pulse
        for (int c = 0; c <= 7; c++) begin
            el = (c >= 5) ? 4'h1 : 4'h5;
            cycle(1'b1, 4'h1, 2'b11, $sformatf("rel%0d", c), el, 4'h0);
        end

        // press again, reach REPEAT, then reset during a repeat pulse
        for (int c = 0; c <= 17; c++) begin
            el = (c >= 5) ? 4'h5 : 4'h1;
            eo = (c == 5 || c == 13 || c == 17) ? 4'h4 : 4'h0;
            cycle(1'b1, 4'h5, 2'b11, $sformatf("prerst%0d", c), el, eo);
        end
        reset = 1'b0;
        #1;
        checkOutput("asyncReset", 4'h0, 4'h0);
        for (int c = 0; c < 2; c++) begin
            cycle(1'b0, 4'h5, 2'b11, $sformatf("inrst%0d", c), 4'h0, 4'h0);
        end
        // both held keys re-qualify as fresh presses after reset release
        for (int c = 0; c <= 14; c++) begin
            el = (c >= 5) ? 4'h5 : 4'h0;
            eo = (c == 5 || c == 13) ? 4'h5 : 4'h0;
            cycle(1'b1, 4'h5, 2'b11, $sformatf("postrst%0d", c), el, eo);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
